// File: rtl/mem_stage.sv
// Pipeline memory stage: issues loads/stores over a req/ready data-memory port,
// formats load data and registers results into the MEM latch. Optional: MEM_FWD_EN.
`ifndef AGEX_latch_WIDTH
`define AGEX_latch_WIDTH 204
`endif
`ifndef MEM_latch_WIDTH
`define MEM_latch_WIDTH 172
`endif
`ifndef from_MEM_to_AGEX_WIDTH
`define from_MEM_to_AGEX_WIDTH 39
`endif
`ifndef from_MEM_to_DE_WIDTH
`define from_MEM_to_DE_WIDTH 7
`endif

module mem_stage #(
   parameter int DBITS   = 32,
   parameter int REGBITS = 5
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [`AGEX_latch_WIDTH-1:0]       from_AGEX_latch,
   output logic [`MEM_latch_WIDTH-1:0]        MEM_latch_out,
   output logic [`from_MEM_to_AGEX_WIDTH-1:0] from_MEM_to_AGEX,
   output logic [`from_MEM_to_DE_WIDTH-1:0]   from_MEM_to_DE,
   output logic                               dmem_req,
   output logic                               dmem_we,
   output logic [DBITS-1:0]                   dmem_addr,
   output logic [3:0]                         dmem_wstrb,
   output logic [DBITS-1:0]                   dmem_wdata,
   input  logic                               dmem_ready,
   input  logic [DBITS-1:0]                   dmem_rdata,
   output logic                               state_dbg
);

   localparam int OPBITS = 6;
   localparam logic [OPBITS-1:0] OP_LB  = 6'd8;
   localparam logic [OPBITS-1:0] OP_LBU = 6'd9;
   localparam logic [OPBITS-1:0] OP_LH  = 6'd10;
   localparam logic [OPBITS-1:0] OP_LHU = 6'd11;
   localparam logic [OPBITS-1:0] OP_LW  = 6'd12;
   localparam logic [OPBITS-1:0] OP_SB  = 6'd13;
   localparam logic [OPBITS-1:0] OP_SH  = 6'd14;
   localparam logic [OPBITS-1:0] OP_SW  = 6'd15;

   typedef struct packed {
      logic [DBITS-1:0]   inst;
      logic [DBITS-1:0]   PC;
      logic [OPBITS-1:0]  op_I;
      logic [DBITS-1:0]   inst_count;
      logic [REGBITS-1:0] reg_dest;
      logic [DBITS-1:0]   result;
      logic [DBITS-1:0]   st_data;
      logic               wr_reg;
      logic [DBITS-1:0]   bus_canary;
   } agex_t;

   typedef struct packed {
      logic [DBITS-1:0]   inst;
      logic [DBITS-1:0]   PC;
      logic [OPBITS-1:0]  op_I;
      logic [DBITS-1:0]   inst_count;
      logic [REGBITS-1:0] reg_dest;
      logic [DBITS-1:0]   wb_val;
      logic               wr_reg;
      logic [DBITS-1:0]   bus_canary;
   } mem_t;

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   agex_t      ag;
   mem_t       mem_q, mem_d;
   state_t     state_q, state_d;
   logic [1:0] off;
   logic       is_load, is_store, misaligned, access, mem_stall, wr_eff;
   logic [7:0]       sel_byte;
   logic [15:0]      sel_half;
   logic [DBITS-1:0] load_val;
   logic             fwd_valid;
   logic [REGBITS-1:0] fwd_dest;
   logic [DBITS-1:0]   fwd_val;

   assign ag  = from_AGEX_latch;
   assign off = ag.result[1:0];

   always_comb begin
      is_load    = 1'b0;
      is_store   = 1'b0;
      misaligned = 1'b0;
      case (ag.op_I)
         OP_LB, OP_LBU: is_load = 1'b1;
         OP_LH, OP_LHU: begin is_load  = 1'b1; misaligned = off[0];         end
         OP_LW:         begin is_load  = 1'b1; misaligned = (off != 2'b00); end
         OP_SB:         is_store = 1'b1;
         OP_SH:         begin is_store = 1'b1; misaligned = off[0];         end
         OP_SW:         begin is_store = 1'b1; misaligned = (off != 2'b00); end
         default:       ;
      endcase
   end

   assign access = (is_load || is_store) && !misaligned;

   // FSM: WAIT keeps the request up; the AGEX latch is held by mem_stall meanwhile.
   always_comb begin
      state_d  = state_q;
      dmem_req = 1'b0;
      case (state_q)
         IDLE: begin
            dmem_req = access;
            if (access && !dmem_ready) state_d = WAIT;
         end
         WAIT: begin
            dmem_req = 1'b1;
            if (dmem_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (reset) begin
         dmem_req = 1'b0;
         state_d  = IDLE;
      end
   end

   assign mem_stall = dmem_req && !dmem_ready;
   assign state_dbg = state_q;

   assign dmem_we   = is_store;
   assign dmem_addr = {ag.result[DBITS-1:2], 2'b00};

   always_comb begin
      dmem_wstrb = 4'b0000;
      dmem_wdata = ag.st_data;
      case (ag.op_I)
         OP_SB: begin
            dmem_wstrb = 4'b0001 << off;
            dmem_wdata = {(DBITS/8){ag.st_data[7:0]}};
         end
         OP_SH: begin
            dmem_wstrb = 4'b0011 << off;
            dmem_wdata = {(DBITS/16){ag.st_data[15:0]}};
         end
         OP_SW:   dmem_wstrb = 4'b1111;
         default: ;
      endcase
   end

   assign sel_byte = dmem_rdata[{off, 3'b000} +: 8];
   assign sel_half = dmem_rdata[{off[1], 4'b0000} +: 16];

   always_comb begin
      load_val = dmem_rdata;
      case (ag.op_I)
         OP_LB:   load_val = {{(DBITS-8){sel_byte[7]}}, sel_byte};
         OP_LBU:  load_val = {{(DBITS-8){1'b0}}, sel_byte};
         OP_LH:   load_val = {{(DBITS-16){sel_half[15]}}, sel_half};
         OP_LHU:  load_val = {{(DBITS-16){1'b0}}, sel_half};
         default: ;
      endcase
   end

   // Stores, misaligned accesses and x0 destinations never write back.
   assign wr_eff = ag.wr_reg && !is_store && !misaligned && (ag.reg_dest != '0);

   always_comb begin
      mem_d = '0;
      if (!mem_stall) begin
         mem_d.inst       = ag.inst;
         mem_d.PC         = ag.PC;
         mem_d.op_I       = ag.op_I;
         mem_d.inst_count = ag.inst_count;
         mem_d.reg_dest   = ag.reg_dest;
         mem_d.bus_canary = ag.bus_canary;
         mem_d.wr_reg     = wr_eff;
         if (misaligned || is_store) mem_d.wb_val = '0;
         else if (is_load)           mem_d.wb_val = load_val;
         else                        mem_d.wb_val = ag.result;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         mem_q   <= '0;
      end else begin
         state_q <= state_d;
         mem_q   <= mem_d;
      end
   end

   assign MEM_latch_out = mem_q;

`ifdef MEM_FWD_EN
   assign fwd_valid = mem_q.wr_reg && (mem_q.reg_dest != '0);
   assign fwd_dest  = mem_q.reg_dest;
   assign fwd_val   = mem_q.wb_val;
`else
   assign fwd_valid = 1'b0;
   assign fwd_dest  = '0;
   assign fwd_val   = '0;
`endif

   assign from_MEM_to_AGEX = {mem_stall, fwd_valid, fwd_dest, fwd_val};
   assign from_MEM_to_DE   = {mem_stall, ag.reg_dest, wr_eff};

endmodule
